// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//
// Scan and oversampling sequencer placed in front of adc_controller. It steps
// an external analog mux through the enabled channels. While a channel is
// being sampled it holds the controller's active-low en_ low, so the
// controller runs in continuous mode. For each channel it accumulates
// 2^AVG_SHIFT conversions and emits one decimated result tagged with the
// channel number.
//
// Optional feature macro: ADC_SEQ_ROUND_EN
//   defined   -> decimation rounds to nearest: (sum + 2^(AVG_SHIFT-1)) >> AVG_SHIFT
//   undefined -> decimation truncates:         sum >> AVG_SHIFT
//
// Ports:
//   clk           system clock; all logic runs on the rising edge
//   reset_        synchronous reset, active-low
//   start_        active-low scan request, level-sensitive
//   ch_mask       channel enables, bit i = channel i
//   adc_ack       ack from adc_controller
//   adc_data      conversion data from adc_controller
//   adc_en_       en_ to adc_controller, active-low
//   mux_sel       analog mux select
//   result        decimated average
//   result_ch     channel that result belongs to
//   result_valid  one-cycle pulse; result and result_ch are valid
//   scan_done     one-cycle pulse alongside the last enabled channel's result
//   busy          high in any state except IDLE
module adc_scan_sequencer #(
  parameter int WIDTH         = 12,
  parameter int NUM_CH        = 4,
  parameter int AVG_SHIFT     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      start_,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      adc_ack,
  input  logic [WIDTH-1:0]          adc_data,
  output logic                      adc_en_,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  output logic [WIDTH-1:0]          result,
  output logic [$clog2(NUM_CH)-1:0] result_ch,
  output logic                      result_valid,
  output logic                      scan_done,
  output logic                      busy
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int ACC_W = WIDTH + AVG_SHIFT;
  localparam int CNT_W = AVG_SHIFT + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'((1 << AVG_SHIFT) - 1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  state_t            state_q;
  logic              ack_d_q;
  logic              adc_en_q;
  logic [CH_W-1:0]   mux_sel_q;
  logic [WIDTH-1:0]  result_q;
  logic [CH_W-1:0]   result_ch_q;
  logic              result_valid_q;
  logic              scan_done_q;
  logic [NUM_CH-1:0] mask_q;
  logic [SET_W-1:0]  set_cnt_q;
  logic [CNT_W-1:0]  smp_cnt_q;
  logic [ACC_W-1:0]  acc_q;

  logic              ack_evt;
  logic [ACC_W-1:0]  acc_d;
  logic              nxt_ok_d;
  logic [CH_W-1:0]   nxt_ch_d;

  // The accumulator is sized so the full sum of 2^AVG_SHIFT samples never
  // overflows; with rounding the maximum sum still lands on all-ones.
  function automatic logic [WIDTH-1:0] decimate(input logic [ACC_W-1:0] sum);
`ifdef ADC_SEQ_ROUND_EN
    return WIDTH'((sum + ACC_W'((1 << AVG_SHIFT) >> 1)) >> AVG_SHIFT);
`else
    return WIDTH'(sum >> AVG_SHIFT);
`endif
  endfunction

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] c;
    c = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) c = CH_W'(i);
    end
    return c;
  endfunction

  // Only a rising edge of ack counts, so a long ack is one sample.
  assign ack_evt = adc_ack & ~ack_d_q;
  assign acc_d   = acc_q + ACC_W'(adc_data);

  // Next enabled channel strictly above the current one in the latched mask.
  always_comb begin
    nxt_ok_d = 1'b0;
    nxt_ch_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(mux_sel_q))) begin
        nxt_ok_d = 1'b1;
        nxt_ch_d = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q        <= IDLE;
      ack_d_q        <= 1'b0;
      adc_en_q       <= 1'b1;
      mux_sel_q      <= '0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
      mask_q         <= '0;
      set_cnt_q      <= '0;
      smp_cnt_q      <= '0;
    end else begin
      ack_d_q        <= adc_ack;
      result_valid_q <= 1'b0;
      scan_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          adc_en_q <= 1'b1;
          if (!start_ && (ch_mask != '0)) begin
            mask_q    <= ch_mask;
            mux_sel_q <= lowest_ch(ch_mask);
            set_cnt_q <= '0;
            smp_cnt_q <= '0;
            acc_q     <= '0;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          if (start_) begin
            adc_en_q  <= 1'b1;
            acc_q     <= '0;
            smp_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (set_cnt_q == LAST_SET) begin
            adc_en_q <= 1'b0;
            state_q  <= SAMPLE;
          end else begin
            set_cnt_q <= set_cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          // The final sample takes priority over a simultaneous abort.
          if (ack_evt && (smp_cnt_q == LAST_SMP)) begin
            result_q       <= decimate(acc_d);
            result_ch_q    <= mux_sel_q;
            result_valid_q <= 1'b1;
            scan_done_q    <= ~nxt_ok_d;
            acc_q          <= '0;
            smp_cnt_q      <= '0;
            set_cnt_q      <= '0;
            adc_en_q       <= 1'b1;
            if (start_) begin
              state_q <= IDLE;
            end else if (nxt_ok_d) begin
              mux_sel_q <= nxt_ch_d;
              state_q   <= SETTLE;
            end else if (ch_mask != '0) begin
              mask_q    <= ch_mask;
              mux_sel_q <= lowest_ch(ch_mask);
              state_q   <= SETTLE;
            end else begin
              state_q <= IDLE;
            end
          end else if (start_) begin
            adc_en_q  <= 1'b1;
            acc_q     <= '0;
            smp_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (ack_evt) begin
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_q + 1'b1;
          end
        end
        default: begin
          adc_en_q <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign adc_en_      = adc_en_q;
  assign mux_sel      = mux_sel_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign scan_done    = scan_done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer: behavioural ADC controller + per-channel
// signal source, expected-result queue filled from the scan rules, and an
// independent monitor that checks every result_valid pulse.
module tb_adc_scan_sequencer;
  localparam int WIDTH         = 12;
  localparam int NUM_CH        = 4;
  localparam int AVG_SHIFT     = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int CH_W          = $clog2(NUM_CH);
  localparam int NS            = 1 << AVG_SHIFT;

  logic              clk = 1'b0;
  logic              reset_;
  logic              start_;
  logic [NUM_CH-1:0] ch_mask;
  logic              adc_ack;
  logic [WIDTH-1:0]  adc_data;
  logic              adc_en_;
  logic [CH_W-1:0]   mux_sel;
  logic [WIDTH-1:0]  result;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              scan_done;
  logic              busy;

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .AVG_SHIFT(AVG_SHIFT), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .reset_(reset_), .start_(start_), .ch_mask(ch_mask),
    .adc_ack(adc_ack), .adc_data(adc_data), .adc_en_(adc_en_), .mux_sel(mux_sel),
    .result(result), .result_ch(result_ch), .result_valid(result_valid),
    .scan_done(scan_done), .busy(busy)
  );

  typedef struct {
    int ch;
    int val;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   res_seen = 0;
  int   src[NUM_CH][NS];
  int   adc_cnt, adc_k, adc_per, abort_at, abort_ch;
  bit   aborted_now;
  int   run_len, run_min, run_max;
  bit   watch_on, mux_bad;
  logic [NUM_CH-1:0] watch_mask;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Average of one full burst of a channel's source, by plain arithmetic.
  function automatic int model_avg(int c);
    int sum;
    sum = 0;
    for (int k = 0; k < NS; k++) sum += src[c][k];
`ifdef ADC_SEQ_ROUND_EN
    return (sum + NS / 2) / NS;
`else
    return sum / NS;
`endif
  endfunction

  // One scan: every enabled channel in ascending order, last one flagged done.
  task automatic push_scan(input logic [NUM_CH-1:0] m);
    int hi;
    hi = -1;
    for (int c = 0; c < NUM_CH; c++) if (m[c]) hi = c;
    for (int c = 0; c < NUM_CH; c++)
      if (m[c]) exp_q.push_back('{c, model_avg(c), (c == hi)});
  endtask

  // Monitor: checks every presented result against the expected queue.
  always @(posedge clk) begin
    #1;
    if (result_valid) begin
      res_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result actual ch=%0d val=%0d required none", result_ch, result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_ch", int'(result_ch), mon_e.ch);
        check("result", int'(result), mon_e.val);
        check("scan_done", int'(scan_done), int'(mon_e.done));
      end
    end else if (scan_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL scan_done_without_valid actual=1 required=0");
    end
  end

  // One clock of stimulus: behavioural controller converting back-to-back
  // while en_ is low, sourcing data from the selected mux channel.
  task automatic tick();
    @(negedge clk);
    if (adc_en_) begin
      adc_cnt = 0;
      adc_k   = 0;
      adc_ack = 1'b0;
      adc_per = $urandom_range(2, 6);
    end else begin
      adc_ack = 1'b0;
      adc_cnt++;
      if (adc_cnt >= adc_per) begin
        adc_ack  = 1'b1;
        adc_data = WIDTH'(src[int'(mux_sel)][adc_k % NS]);
        adc_k++;
        adc_cnt  = 0;
        adc_per  = $urandom_range(2, 6);
        if (abort_at != 0 && adc_k == abort_at && int'(mux_sel) == abort_ch) begin
          start_      = 1'b1;
          abort_at    = 0;
          aborted_now = 1'b1;
        end
      end
    end
    if (busy && adc_en_) begin
      run_len++;
    end else begin
      if (busy && !adc_en_ && run_len > 0) begin
        if (run_len < run_min) run_min = run_len;
        if (run_len > run_max) run_max = run_len;
      end
      run_len = 0;
    end
    if (watch_on && busy && !watch_mask[mux_sel]) mux_bad = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", (busy || exp_q.size() != 0) ? 1 : 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adc_en_"}, int'(adc_en_), 1);
    check({tag, "_mux_sel"}, int'(mux_sel), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_result_ch"}, int'(result_ch), 0);
    check({tag, "_result_valid"}, int'(result_valid), 0);
    check({tag, "_scan_done"}, int'(scan_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n, base;
    logic [NUM_CH-1:0] m;
    bit bad;
    reset_ = 1'b0; start_ = 1'b1; ch_mask = '0; adc_ack = 1'b0; adc_data = '0;
    adc_cnt = 0; adc_k = 0; adc_per = 3; abort_at = 0; abort_ch = 0; aborted_now = 1'b0;
    run_len = 0; run_min = 1000; run_max = 0; watch_on = 1'b0; mux_bad = 1'b0;
    watch_mask = '1;
    repeat (3) tick();
    reset_ = 1'b1;
    tick();
    check_reset_outputs("reset");

    // Full single scan with constant inputs; start_ released on the final ack.
    for (int k = 0; k < NS; k++) begin
      src[0][k] = 100; src[1][k] = 200; src[2][k] = 3000; src[3][k] = 4095;
    end
    ch_mask = 4'b1111; abort_ch = 3; abort_at = NS;
    push_scan(ch_mask);
    check("busy_before_start", int'(busy), 0);
    start_ = 1'b0;
    tick();
    check("busy_after_start", int'(busy), 1);
    wait_idle(3000);
    check("scan1_adc_en_idle", int'(adc_en_), 1);

    // Continuous scanning of channels 0 and 2 with random data.
    for (int k = 0; k < NS; k++) begin
      src[0][k] = $urandom_range(0, 4095);
      src[2][k] = $urandom_range(0, 4095);
    end
    ch_mask = 4'b0101;
    push_scan(ch_mask);
    push_scan(ch_mask);
    watch_mask = 4'b0101; watch_on = 1'b1;
    base = res_seen;
    start_ = 1'b0;
    n = 0;
    while (res_seen < base + 4 && n < 3000) begin
      tick();
      n++;
    end
    start_ = 1'b1;
    watch_on = 1'b0;
    wait_idle(200);
    check("mux_skipped_disabled", int'(mux_bad), 0);

    // Alternating 10/11 input: truncation gives 10, rounding gives 11.
    for (int k = 0; k < NS; k++) src[0][k] = 10 + (k % 2);
    ch_mask = 4'b0001; abort_ch = 0; abort_at = NS;
    push_scan(ch_mask);
    start_ = 1'b0;
    tick();
    wait_idle(1000);

    // Abort after 5 acks, then restart with 777 to expose stale accumulation.
    for (int k = 0; k < NS; k++) src[0][k] = 3333;
    ch_mask = 4'b0001; abort_ch = 0; abort_at = 5; aborted_now = 1'b0;
    start_ = 1'b0;
    n = 0;
    while (!aborted_now && n < 1000) begin
      tick();
      n++;
    end
    check("abort_point_reached", int'(aborted_now), 1);
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_adc_en_", int'(adc_en_), 1);
    check("abort_result_valid", int'(result_valid), 0);
    for (int k = 0; k < NS; k++) src[0][k] = 777;
    abort_at = NS;
    push_scan(ch_mask);
    start_ = 1'b0;
    tick();
    wait_idle(1000);

    // start_ raised with the final ack of ch0 in a two-channel scan:
    // ch0 result is still delivered, ch1 is never started.
    for (int k = 0; k < NS; k++) begin
      src[0][k] = $urandom_range(0, 4095);
      src[1][k] = $urandom_range(0, 4095);
    end
    ch_mask = 4'b0011; abort_ch = 0; abort_at = NS;
    exp_q.push_back('{0, model_avg(0), 1'b0});
    start_ = 1'b0;
    tick();
    wait_idle(1000);
    repeat (4) tick();
    check("completion_then_idle", int'(busy), 0);

    // Ack pulses while idle must be ignored.
    ch_mask = 4'b1111;
    tick();
    adc_ack = 1'b1;
    adc_data = 12'd123;
    tick();
    repeat (5) tick();
    check("idle_ack_ignored", int'(busy), 0);

    // Random masks and random data, each a single complete scan.
    for (int it = 0; it < 3; it++) begin
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NS; k++) src[c][k] = $urandom_range(0, 4095);
      for (int c = 0; c < NUM_CH; c++) if (m[c]) abort_ch = c;
      abort_at = NS;
      ch_mask = m;
      push_scan(m);
      start_ = 1'b0;
      tick();
      wait_idle(3000);
    end

    // Reset in the middle of sampling.
    ch_mask = 4'b0001; abort_at = 0;
    start_ = 1'b0;
    n = 0;
    while (adc_k < 3 && n < 1000) begin
      tick();
      n++;
    end
    check("reached_sample", (adc_k >= 3) ? 1 : 0, 1);
    reset_ = 1'b0;
    start_ = 1'b1;
    tick();
    check_reset_outputs("midreset");
    reset_ = 1'b1;
    tick();

    // Empty mask: start_ low must not leave IDLE.
    ch_mask = '0;
    start_ = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (busy || !adc_en_) bad = 1'b1;
    end
    check("mask0_stays_idle", int'(bad), 0);
    start_ = 1'b1;
    repeat (3) tick();

    check("settle_len_min", run_min, SETTLE_CYCLES);
    check("settle_len_max", run_max, SETTLE_CYCLES);
    check("expected_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Multi-channel scan and oversampling sequencer sitting in front of `adc_controller`. It steps an external analog mux through the enabled channels and drives the controller's active-low `en_` in continuous mode. For each channel it accumulates 2^AVG_SHIFT conversions and emits one decimated WIDTH-bit result tagged with its channel number.

## Interface
- WIDTH, 12, ADC result width; must match `adc_controller`.
- NUM_CH, 4, number of mux channels (≥2).
- AVG_SHIFT, 4, log2 of samples per channel (0 = single sample).
- SETTLE_CYCLES, 2, cycles `adc_en_` is held high after each mux change (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_  in  1  synchronous reset, active-low.
- start_  in  1  active-low scan request, level-sensitive.
- ch_mask  in  NUM_CH  channel enables; bit i = channel i.
- adc_ack  in  1  `ack` from `adc_controller`.
- adc_data  in  WIDTH  `data` from `adc_controller`.
- adc_en_  out  1  to `adc_controller` `en_`, active-low.
- mux_sel  out  $clog2(NUM_CH)  analog mux select.
- result  out  WIDTH  decimated average.
- result_ch  out  $clog2(NUM_CH)  channel of `result`.
- result_valid  out  1  one-cycle pulse, `result` and `result_ch` valid.
- scan_done  out  1  one-cycle pulse on the last enabled channel's result.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, SETTLE, SAMPLE.
- Registered `ack_d` is kept. An ack event is `adc_ack & ~ack_d`.
- IDLE → SETTLE when `start_`=0 and `ch_mask`≠0:
  - `ch_mask` is latched.
  - `mux_sel` is set to the lowest enabled channel.
  - Settle counter, sample counter and accumulator are cleared.
- IDLE with `ch_mask`=0: the block stays in IDLE regardless of `start_`.
- SETTLE:
  - `adc_en_`=1.
  - After SETTLE_CYCLES cycles the block moves to SAMPLE.
  - Ack events are ignored.
- SAMPLE:
  - `adc_en_`=0, so the controller converts back-to-back.
  - Each ack event adds `adc_data` to the accumulator (WIDTH+AVG_SHIFT bits, cannot overflow) and increments the sample counter.
- On the 2^AVG_SHIFT-th ack event:
  - `result` ← decimate(acc + adc_data).
  - `result_ch` ← `mux_sel`.
  - `result_valid` ← 1.
  - Accumulator and counter are cleared.
  - `adc_en_` ← 1, which aborts the controller's next conversion.
  - Next channel is the next higher enabled bit of the latched mask: `mux_sel` updates and the block enters SETTLE.
  - If no higher enabled bit exists: `scan_done` ← 1. Then, if `start_`=0, `ch_mask` is re-latched and the scan restarts at the lowest enabled channel in SETTLE; otherwise the block enters IDLE.
- Decimation (truncate): (sum >> AVG_SHIFT). The rounding variant is in Configuration.
- Abort: `start_`=1 in SETTLE or SAMPLE → next edge IDLE.
  - `adc_en_`=1.
  - Partial accumulation is discarded.
  - No `result_valid`.
- Simultaneous abort and final ack event: completion wins. The result is delivered, then the block enters IDLE.
- Ack events in IDLE are ignored.

## Timing
- Reset values: `adc_en_`=1, `mux_sel`=0, `result`=0, `result_ch`=0, `result_valid`=0, `scan_done`=0, `busy`=0, `ack_d`=0, state IDLE.
- Reset overrides every other input on the same edge, including mid-conversion.
- `busy` rises the cycle after `start_` is sampled low.
- `adc_en_` falls exactly SETTLE_CYCLES cycles after `mux_sel` changes.
- `result_valid` is high the cycle after `adc_ack` rises for the final sample. `scan_done` is coincident with `result_valid` for the last channel.
- `result` and `result_ch` hold their values until the next `result_valid`.
- Per-channel latency: SETTLE_CYCLES + 1 + 2^AVG_SHIFT × (controller conversion period).

## Configuration
- `ADC_SEQ_ROUND_EN` defined: decimation rounds to nearest.
  - result = (sum + 2^(AVG_SHIFT−1)) >> AVG_SHIFT.
  - The rounding term is 0 when AVG_SHIFT=0.
  - The maximum sum still maps to at most all-ones, so no saturation logic is needed.
- Undefined: truncation, result = sum >> AVG_SHIFT.

## Test plan
- Mask 4'b1111, `start_` low for one scan, constant channel inputs 100 / 200 / 3000 / 4095 → four `result_valid` pulses with ch0..3 and exact values. `scan_done` is coincident with ch3. The block is in IDLE afterwards.
- Mask 4'b0101, `start_` held low → results repeat ch0, ch2, ch0, ch2. `mux_sel` is never 1 or 3. `adc_en_` is high for exactly SETTLE_CYCLES between channels.
- Ch0 input alternating 10 / 11 (8 samples each, sum 168) → `result`=10 without `ADC_SEQ_ROUND_EN`, 11 with it.
- `start_` raised after 5 acks:
  - Next edge: IDLE, `adc_en_`=1, no `result_valid`.
  - Restart with input 777: `result`=777, proving no stale accumulation.
- `start_` raised on the same cycle as the 16th ack event → `result_valid` is issued, then IDLE.
- `reset_` low mid-SAMPLE → all outputs at reset values after the edge. Mask 0 with `start_` low → `busy` stays 0 and `adc_en_` stays 1.
